apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter: ADDR_W, 32, APB address width.
REQ-003 Parameter: DATA_W, 32, APB data width.
REQ-004 Parameter: TIMEOUT, 16, max ACCESS cycles without pready before abort (>=2).
REQ-005 Port: pclk  input  1  APB clock, all logic on rising edge.
REQ-006 Port: preset  input  1  synchronous active-high reset.
REQ-007 Port: cmd_valid  input  1  user requests a transfer.
REQ-008 Port: cmd_ready  output  1  block accepts command this cycle.
REQ-009 Port: cmd_write  input  1  1=write, 0=read.
REQ-010 Port: cmd_addr  input  ADDR_W  transfer address.
REQ-011 Port: cmd_wdata  input  DATA_W  write data.
REQ-012 Port: rsp_valid  output  1  response available.
REQ-013 Port: rsp_ready  input  1  user consumes response.
REQ-014 Port: rsp_rdata  output  DATA_W  read data (0 for writes and timeouts).
REQ-015 Port: rsp_err  output  1  slave error or timeout.
REQ-016 Port: rsp_timeout  output  1  transfer aborted by timeout.
REQ-017 Port: psel, penable, pwrite  output  1 each  APB control.
REQ-018 Port: paddr  output  ADDR_W; pwdata  output  DATA_W  APB address/write data.
REQ-019 Port: prdata  input  DATA_W; pready, pslverr  input  1 each  APB slave response.

Function
REQ-020 FSM states SHALL be IDLE, SETUP, ACCESS, RESP; all APB and rsp_* outputs registered or decoded from state registers only.
REQ-021 IDLE: cmd_ready=1, psel=0, penable=0; on cmd_valid=1 the command SHALL be captured and state -> SETUP.
REQ-022 cmd_ready SHALL be 0 in SETUP, ACCESS, RESP; commands presented then are ignored.
REQ-023 SETUP: psel=1, penable=0, exactly one cycle, pready/pslverr ignored; -> ACCESS.
REQ-024 ACCESS: psel=1, penable=1; paddr, pwrite, pwdata SHALL equal captured values and stay stable across SETUP and ACCESS.
REQ-025 pwdata SHALL be 0 for reads; paddr/pwrite/pwdata hold last value while psel=0.
REQ-026 ACCESS with pready=1: capture prdata (read) or 0 (write) into rsp_rdata, rsp_err=pslverr, rsp_timeout=0; -> RESP.
REQ-027 Wait counter (width clog2(TIMEOUT)) SHALL clear on entering ACCESS and increment each ACCESS cycle with pready=0.
REQ-028 ACCESS with pready=0 and counter==TIMEOUT-1: rsp_err=1, rsp_timeout=1, rsp_rdata=0; -> RESP (ACCESS lasts at most TIMEOUT cycles).
REQ-029 pready=1 in the same cycle as timeout condition SHALL complete normally (pready wins).
REQ-030 RESP: psel=0, penable=0, rsp_valid=1, rsp_* stable until rsp_ready=1; then -> IDLE.
REQ-031 Latency: command accepted at edge k -> psel=1 cycle k+1, penable=1 cycle k+2, zero-wait rsp_valid=1 cycle k+3; minimum 4 cycles per transfer.
REQ-032 penable SHALL never be 1 while psel=0.

Reset
REQ-033 preset=1 at an edge SHALL force IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, wait counter=0; cmd_ready=1 the cycle after reset releases.
REQ-034 Reset in SETUP/ACCESS/RESP SHALL abandon the transfer with no response delivered; prdata/pready ignored during reset.

Verification
REQ-035 Write addr 0x5 data 0xDEADBEEF, pready=1 first ACCESS cycle -> pwrite=1, paddr=0x5, pwdata=0xDEADBEEF in SETUP+ACCESS; rsp_valid at k+3, rsp_err=0, rsp_rdata=0.
REQ-036 Read addr 0x5, slave holds pready=0 for 3 ACCESS cycles then prdata=0xDEADBEEF, pready=1 -> penable high 4 cycles, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-037 Read addr 0x40, pready=1 with pslverr=1 -> rsp_err=1, rsp_timeout=0, rsp_rdata=prdata value.
REQ-038 TIMEOUT=16, pready held 0 -> exactly 16 ACCESS cycles, then rsp_err=1, rsp_timeout=1, rsp_rdata=0; pready=1 on 16th cycle instead -> normal completion.
REQ-039 rsp_ready held 0 for 5 cycles with cmd_valid=1 -> rsp_* stable, cmd_ready=0, psel=0 throughout; second command accepted cycle after rsp_ready=1.
REQ-040 preset=1 during ACCESS -> next cycle psel=0, penable=0, rsp_valid=0, cmd_ready=1 after release.

Source files
------------

// File: rtl/apb_master.sv
// apb_master: single-outstanding APB master.
// A user command is captured in IDLE, driven as an APB SETUP/ACCESS pair,
// and its result is held on the rsp_* port until the user takes it.
// ACCESS is aborted with an error after TIMEOUT cycles without pready.
//
// Handshakes: cmd and rsp are valid/ready pairs. A transfer happens on a
// rising pclk edge where both valid and ready are 1. cmd_ready is 1 only in
// IDLE and does not depend on cmd_valid. Once rsp_valid is 1, the rsp_*
// values stay constant until the edge where rsp_ready is 1.
module apb_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;

  // Last permitted ACCESS cycle; pready in this cycle still completes normally.
  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    psel      = 1'b0;
    penable   = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = SETUP;
      end
      SETUP: begin
        psel      = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready || timeout_hit) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign dbg_state = state;

  // Command capture, wait counter and response capture.
  always_ff @(posedge pclk) begin
    if (preset) begin
      paddr       <= '0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
      wait_cnt    <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            paddr  <= cmd_addr;
            pwrite <= cmd_write;
            pwdata <= cmd_write ? cmd_wdata : '0;
          end
        end
        SETUP: begin
          wait_cnt <= '0;
        end
        ACCESS: begin
          if (pready) begin
            rsp_rdata   <= pwrite ? '0 : prdata;
            rsp_err     <= pslverr;
            rsp_timeout <= 1'b0;
          end else if (timeout_hit) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: randomized scoreboard bench for apb_master.
// Drivers change inputs 1 time unit after a rising edge; the monitor samples
// on the falling edge. The slave model answers each ACCESS according to a
// per-transfer plan (wait cycles, error flag, read data) queued at issue time.
module tb_apb_master;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;
  localparam int EW      = 8 + 2 + DATA_W;   // {access cycles, timeout, err, rdata}
  localparam int AW      = 1 + ADDR_W + DATA_W;  // {pwrite, paddr, pwdata}

  logic              pclk;
  logic              preset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;
  logic [1:0]        dbg_state;

  apb_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .dbg_state(dbg_state)
  );

  // Clock and watchdog.
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  // Scoreboard state.
  int checks = 0;
  int fails  = 0;
  logic [EW-1:0] exp_q[$];
  logic [AW-1:0] apb_q[$];

  typedef struct {
    int              wt;
    bit              se;
    logic [DATA_W-1:0] rd;
  } slv_t;
  slv_t slv_q[$];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Slave model: pready rises on ACCESS cycle index wt (0-based); random junk
  // on pready/pslverr/prdata whenever the master must ignore them.
  slv_t cur;
  int   n_acc;
  initial begin
    pready = 1'b0; pslverr = 1'b0; prdata = '0;
    n_acc = 0; cur.wt = 0; cur.se = 1'b0; cur.rd = '0;
    forever begin
      @(posedge pclk); #1;
      if (psel && !penable) begin
        if (slv_q.size() == 0) check("slave_plan_missing", 1, 0);
        else cur = slv_q.pop_front();
        n_acc   = 0;
        pready  = 1'($urandom);
        pslverr = 1'($urandom);
        prdata  = $urandom;
      end else if (psel && penable) begin
        pready  = (n_acc == cur.wt);
        pslverr = (n_acc == cur.wt) ? cur.se : 1'($urandom);
        prdata  = (n_acc == cur.wt) ? cur.rd : $urandom;
        n_acc++;
      end else begin
        pready  = 1'($urandom);
        pslverr = 1'($urandom);
        prdata  = $urandom;
      end
    end
  end

  // Monitor: APB field checks at SETUP, stability in ACCESS and RESP,
  // response comparison on the rsp handshake.
  logic [AW-1:0]       setup_v;
  logic [DATA_W+3:0]   rsp_v;
  logic [EW-1:0]       exp_e;
  int                  acc_cnt = 0;
  bit                  in_resp = 1'b0;
  initial begin
    forever begin
      @(negedge pclk);
      if (preset) begin
        acc_cnt = 0;
        in_resp = 1'b0;
      end else begin
        check("penable_implies_psel", penable & ~psel, 0);
        if (psel && !penable) begin
          setup_v = {pwrite, paddr, pwdata};
          acc_cnt = 0;
          if (apb_q.size() == 0) check("unexpected_setup", 1, 0);
          else check("setup_fields", setup_v, apb_q.pop_front());
        end
        if (psel && penable) begin
          check("access_fields_stable", {pwrite, paddr, pwdata}, setup_v);
          acc_cnt++;
        end
        if (rsp_valid) begin
          if (!in_resp) begin
            in_resp = 1'b1;
            rsp_v   = {dbg_state, rsp_timeout, rsp_err, rsp_rdata};
          end else begin
            check("rsp_stable", {dbg_state, rsp_timeout, rsp_err, rsp_rdata}, rsp_v);
          end
          check("resp_bus_idle", {cmd_ready, psel, penable}, 0);
          if (rsp_ready) begin
            in_resp = 1'b0;
            if (exp_q.size() == 0) check("unexpected_response", 1, 0);
            else begin
              exp_e = exp_q.pop_front();
              check("response", {8'(acc_cnt), rsp_timeout, rsp_err, rsp_rdata}, exp_e);
            end
          end
        end
      end
    end
  end

  // Reference model: what the user should see for one planned transfer.
  function automatic int access_cycles(input int wt);
    return (wt >= TIMEOUT) ? TIMEOUT : wt + 1;
  endfunction

  function automatic logic [EW-1:0] model_rsp(input bit w, input int wt, input bit se,
                                               input logic [DATA_W-1:0] rd);
    if (wt >= TIMEOUT) return {8'(TIMEOUT), 1'b1, 1'b1, {DATA_W{1'b0}}};
    return {8'(wt + 1), 1'b0, se, (w ? {DATA_W{1'b0}} : rd)};
  endfunction

  // Driver: present a command, wait for acceptance, queue the expectations.
  task automatic issue(input bit w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input int wt, input bit se, input logic [DATA_W-1:0] rd,
                       output int waited);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    waited = 0;
    do begin
      @(negedge pclk);
      waited++;
    end while (!cmd_ready && waited < 50);
    if (!cmd_ready) check("cmd_accept_bound", 0, 1);
    @(posedge pclk);
    apb_q.push_back({w, a, (w ? d : {DATA_W{1'b0}})});
    slv_q.push_back('{wt: wt, se: se, rd: rd});
    exp_q.push_back(model_rsp(w, wt, se, rd));
    #1;
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
  endtask

  // Driver: take the response after holding rsp_ready low for 'hold' cycles.
  // lat = falling edges from the acceptance edge until rsp_valid is seen.
  task automatic respond(input int hold, output int lat);
    lat = 0;
    rsp_ready = (hold == 0);
    do begin
      @(negedge pclk);
      lat++;
    end while (!rsp_valid && lat < 100);
    if (!rsp_valid) check("rsp_valid_bound", 0, 1);
    if (hold > 0) begin
      repeat (hold) @(posedge pclk);
      #1 rsp_ready = 1'b1;
    end
    @(posedge pclk);
    #1 rsp_ready = 1'b0;
  endtask

  int lat;
  int waited;
  int wt;
  bit w;
  logic [DATA_W-1:0] rd;

  // Main sequence.
  initial begin
    preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check("reset_apb", {psel, penable, pwrite, paddr, pwdata}, 0);
    check("reset_rsp", {rsp_valid, rsp_timeout, rsp_err, rsp_rdata}, 0);
    @(posedge pclk); #1 preset = 1'b0;
    @(negedge pclk);
    check("cmd_ready_after_reset", cmd_ready, 1);
    @(posedge pclk); #1;

    // Zero-wait write.
    issue(1'b1, 32'h5, 32'hDEADBEEF, 0, 1'b0, 32'h1234_5678, waited);
    respond(0, lat);
    check("zero_wait_latency", lat, 3);

    // Read with three wait states.
    issue(1'b0, 32'h5, 32'h0BAD_0BAD, 3, 1'b0, 32'hDEADBEEF, waited);
    respond(0, lat);
    check("wait3_latency", lat, 6);

    // Read with slave error.
    issue(1'b0, 32'h40, 32'h0, 0, 1'b1, 32'hA5A5_5A5A, waited);
    respond(1, lat);
    check("slverr_latency", lat, 3);

    // Timeout and the last-cycle pready boundary.
    issue(1'b0, 32'h80, 32'h0, TIMEOUT, 1'b0, 32'hFFFF_0000, waited);
    respond(0, lat);
    check("timeout_latency", lat, TIMEOUT + 2);
    issue(1'b0, 32'h84, 32'h0, TIMEOUT - 1, 1'b0, 32'h0F0F_F0F0, waited);
    respond(0, lat);
    check("last_cycle_pready_latency", lat, TIMEOUT + 2);

    // Response held off for 5 cycles with another command waiting.
    issue(1'b0, 32'h100, 32'h0, 1, 1'b0, 32'hCAFE_F00D, waited);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h123; cmd_wdata = 32'h55;
    respond(5, lat);
    check("held_rsp_latency", lat, 4);
    issue(1'b1, 32'h123, 32'h55, 0, 1'b0, 32'h0, waited);
    check("second_cmd_accept_delay", waited, 1);
    respond(0, lat);

    // Reset in the middle of ACCESS abandons the transfer.
    issue(1'b0, 32'h200, 32'h0, 100, 1'b0, 32'h0, waited);
    repeat (2) @(negedge pclk);
    @(posedge pclk); #1 preset = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    check("reset_in_access_bus", {psel, penable, rsp_valid}, 0);
    @(posedge pclk); #1 preset = 1'b0;
    void'(exp_q.pop_back());
    @(negedge pclk);
    check("cmd_ready_after_access_reset", cmd_ready, 1);
    @(posedge pclk); #1;

    // Randomized transfers.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0:       wt = 0;
        1, 2:    wt = $urandom_range(0, 4);
        3:       wt = TIMEOUT - 1;
        4:       wt = TIMEOUT;
        default: wt = $urandom_range(0, TIMEOUT + 3);
      endcase
      w  = 1'($urandom);
      rd = $urandom;
      issue(w, $urandom, $urandom, wt, 1'($urandom), rd, waited);
      respond($urandom_range(0, 3), lat);
      check("random_latency", lat, access_cycles(wt) + 2);
    end

    repeat (2) @(negedge pclk);
    check("scoreboard_drained", exp_q.size() + apb_q.size() + slv_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
